// File: rtl/dg0045_pkg.sv
// Shared definitions for the DG0045 program-ROM fetch stage: FSM state
// encoding, bus widths, the NOP instruction byte and a small saturating
// increment helper used by the scan-match counter.
package dg0045_pkg;

    localparam int PC_W   = 10;
    localparam int PCHL_W = 5;

    localparam logic [7:0] NOP_BYTE = 8'h00;

    typedef enum logic [2:0] {
        LO_SET,
        LO_WAIT,
        HI_SET,
        HI_WAIT,
        CMP,
        REQ,
        WAIT
    } fetch_state_t;

    // Two-bit increment that sticks at 3 instead of wrapping to 0.
    function automatic logic [1:0] sat_inc2(input logic [1:0] v);
        return (v == 2'b11) ? v : v + 2'd1;
    endfunction

endpackage

// File: rtl/dg0045_pc_demux.sv
// PC_HL de-multiplexer for the DG0045 fetch stage.
// Drives the core's PC_MUX select, waits SETTLE cycles after each toggle
// and captures the low and high halves of the program counter. The fetch
// FSM in the top tells this block which scan phase it is in through four
// one-hot phase strobes; this block reports when the current settle window
// has elapsed and when a full {hi,lo} candidate is ready.
module dg0045_pc_demux
    import dg0045_pkg::*;
#(
    parameter int SETTLE = 1
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              lo_set,
    input  logic              lo_wait,
    input  logic              hi_set,
    input  logic              hi_wait,
    input  logic [PCHL_W-1:0] pc_hl,
    output logic              pc_mux,
    output logic              settle_done,
    output logic              scan_done,
    output logic [PC_W-1:0]   cand
);

    localparam logic [2:0] SETTLE_LAST = 3'(SETTLE - 1);

    logic [2:0]        settle_cnt;
    logic [PCHL_W-1:0] lo;
    logic [PCHL_W-1:0] hi;
    logic              in_wait;

    assign in_wait     = lo_wait | hi_wait;
    assign settle_done = in_wait && (settle_cnt >= SETTLE_LAST);
    assign scan_done   = hi_wait && settle_done;
    assign cand        = {hi, lo};

    // Select register: only the SET phases move it, so it holds its last
    // value while the top is busy issuing or waiting on a ROM read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_mux <= 1'b0;
        end else if (lo_set) begin
            pc_mux <= 1'b0;
        end else if (hi_set) begin
            pc_mux <= 1'b1;
        end
    end

    // Settle counter: cleared on every select toggle, counts through the
    // following WAIT phase and saturates rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_cnt <= 3'd0;
        end else if (lo_set || hi_set) begin
            settle_cnt <= 3'd0;
        end else if (in_wait && !settle_done && (settle_cnt != 3'd7)) begin
            settle_cnt <= settle_cnt + 3'd1;
        end
    end

    // Half-address capture on the last cycle of each settle window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo <= '0;
            hi <= '0;
        end else begin
            if (lo_wait && settle_done) begin
                lo <= pc_hl;
            end
            if (hi_wait && settle_done) begin
                hi <= pc_hl;
            end
        end
    end

endmodule

// File: rtl/dg0045_rom_fetch.sv
// DG0045 program-ROM fetch stage (top).
// Continuously scans the core's multiplexed PC_HL bus, and once the
// assembled 10-bit address has been seen unchanged for STABLE_SCANS scans
// and differs from the address already fetched, issues one req/ack read
// and presents the returned byte on a registered output to the core.
// Optional build macro DG0045_FETCH_TIMEOUT_EN bounds the ack wait to
// TIMEOUT cycles, substitutes a NOP on expiry and raises a sticky
// fetch_err flag; without it the wait is unbounded and fetch_err is 0.
module dg0045_rom_fetch
    import dg0045_pkg::*;
#(
    parameter int SETTLE       = 1,
    parameter int STABLE_SCANS = 1,
    parameter int TIMEOUT      = 15
)(
    input  logic              clk,
    input  logic              rst,
    input  logic [PCHL_W-1:0] pc_hl,
    output logic              pc_mux,
    output logic              rom_req,
    output logic [PC_W-1:0]   rom_addr,
    input  logic              rom_ack,
    input  logic [7:0]        rom_data,
    output logic [7:0]        rom_byte,
    output logic              fetch_valid,
    output logic              fetch_err
);

    localparam logic [1:0] MATCH_TARGET = 2'(STABLE_SCANS);

    fetch_state_t    state;
    fetch_state_t    state_next;

    logic            settle_done;
    logic            scan_done;
    logic [PC_W-1:0] cand;

    logic [PC_W-1:0] cur_addr;
    logic            cur_addr_valid;
    logic [PC_W-1:0] prev_cand;
    logic [1:0]      match_cnt;
    logic [1:0]      match_next;

    logic            cand_is_cur;
    logic            launch;
    logic            ack_take;
    logic            timeout_hit;

    dg0045_pc_demux #(
        .SETTLE (SETTLE)
    ) u_demux (
        .clk         (clk),
        .rst         (rst),
        .lo_set      (state == LO_SET),
        .lo_wait     (state == LO_WAIT),
        .hi_set      (state == HI_SET),
        .hi_wait     (state == HI_WAIT),
        .pc_hl       (pc_hl),
        .pc_mux      (pc_mux),
        .settle_done (settle_done),
        .scan_done   (scan_done),
        .cand        (cand)
    );

    // A candidate equal to the address already held needs no read; anything
    // else counts toward stability, restarting at 1 whenever it changes.
    assign cand_is_cur = cur_addr_valid && (cand == cur_addr);
    assign match_next  = (cand == prev_cand) ? sat_inc2(match_cnt) : 2'd1;
    assign launch      = (state == CMP) && !cand_is_cur && (match_next >= MATCH_TARGET);
    // Acks are only honoured in WAIT; one arriving alongside the rising
    // request (REQ) or during scanning is dropped.
    assign ack_take    = (state == WAIT) && rom_ack;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LO_SET;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: scan lo, scan hi, compare, then optionally one read.
    always_comb begin
        state_next = state;
        unique case (state)
            LO_SET:  state_next = LO_WAIT;
            LO_WAIT: if (settle_done) state_next = HI_SET;
            HI_SET:  state_next = HI_WAIT;
            HI_WAIT: if (scan_done) state_next = CMP;
            CMP:     state_next = launch ? REQ : LO_SET;
            REQ:     state_next = WAIT;
            WAIT:    if (ack_take || timeout_hit) state_next = LO_SET;
            default: state_next = LO_SET;
        endcase
    end

    // Stability tracking across consecutive completed scans.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_cnt <= 2'd0;
            prev_cand <= '0;
        end else if (state == CMP) begin
            if (cand_is_cur) begin
                match_cnt <= 2'd0;
            end else begin
                match_cnt <= match_next;
                prev_cand <= cand;
            end
        end
    end

    // ROM handshake and instruction-byte register. The request and address
    // are launched as the FSM enters REQ so that rom_req is already high
    // there; rom_byte only ever moves on an accepted ack or a timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_addr       <= '0;
            cur_addr_valid <= 1'b0;
            rom_addr       <= '0;
            rom_req        <= 1'b0;
            rom_byte       <= NOP_BYTE;
            fetch_valid    <= 1'b0;
        end else if (launch) begin
            cur_addr       <= cand;
            cur_addr_valid <= 1'b1;
            rom_addr       <= cand;
            rom_req        <= 1'b1;
            fetch_valid    <= 1'b0;
        end else if (ack_take) begin
            rom_byte       <= rom_data;
            fetch_valid    <= 1'b1;
            rom_req        <= 1'b0;
        end else if (timeout_hit) begin
            rom_byte       <= NOP_BYTE;
            fetch_valid    <= 1'b1;
            rom_req        <= 1'b0;
        end
    end

`ifdef DG0045_FETCH_TIMEOUT_EN
    localparam logic [3:0] TIMEOUT_LAST = 4'(TIMEOUT - 1);

    logic [3:0] wait_cnt;
    logic       err_q;

    // Expiry fires on the TIMEOUT-th WAIT cycle unless that cycle acks.
    assign timeout_hit = (state == WAIT) && !rom_ack && (wait_cnt == TIMEOUT_LAST);
    assign fetch_err   = err_q;

    // Cycles spent in WAIT for the current read; idle outside WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 4'd0;
        end else if (state != WAIT) begin
            wait_cnt <= 4'd0;
        end else if (wait_cnt != 4'hF) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign fetch_err   = 1'b0;
`endif

endmodule
